// File: rtl/aemb_pkg.sv
// Shared definitions for the AEMB data Wishbone controller: FSM states and
// big-endian byte-select codes (B0 is the most significant lane).
package aemb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } dwb_state_e;

    localparam logic [3:0] SEL_B0 = 4'h8;
    localparam logic [3:0] SEL_B1 = 4'h4;
    localparam logic [3:0] SEL_B2 = 4'h2;
    localparam logic [3:0] SEL_B3 = 4'h1;
    localparam logic [3:0] SEL_H0 = 4'hC;
    localparam logic [3:0] SEL_H1 = 4'h3;
    localparam logic [3:0] SEL_W  = 4'hF;

endpackage

// File: rtl/aemb_dwb_ctrl_if.sv
// Data Wishbone bus bundle between the AEMB cycle controller (master) and a slave.
interface aemb_dwb_ctrl_if #(
    parameter int DW = 32
);
    logic          dwb_cyc_o;
    logic          dwb_stb_o;
    logic          dwb_we_o;
    logic [DW-1:2] dwb_adr_o;
    logic [3:0]    dwb_sel_o;
    logic [31:0]   dwb_dat_o;
    logic [31:0]   dwb_dat_i;
    logic          dwb_ack_i;
    logic          dwb_err_i;

    modport master (
        output dwb_cyc_o, dwb_stb_o, dwb_we_o, dwb_adr_o, dwb_sel_o, dwb_dat_o,
        input  dwb_dat_i, dwb_ack_i, dwb_err_i
    );

    modport slave (
        input  dwb_cyc_o, dwb_stb_o, dwb_we_o, dwb_adr_o, dwb_sel_o, dwb_dat_o,
        output dwb_dat_i, dwb_ack_i, dwb_err_i
    );
endinterface

// File: rtl/aemb_dwb_lane.sv
// Read-lane steering: right-justifies the selected byte/halfword/word of the
// bus read data and zero-extends it; unsupported select patterns yield zero.
module aemb_dwb_lane
    import aemb_pkg::*;
(
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o
);

    always_comb begin
        dat_o = '0;
        case (sel_i)
            SEL_B0:  dat_o = {24'h0, dat_i[31:24]};
            SEL_B1:  dat_o = {24'h0, dat_i[23:16]};
            SEL_B2:  dat_o = {24'h0, dat_i[15:8]};
            SEL_B3:  dat_o = {24'h0, dat_i[7:0]};
            SEL_H0:  dat_o = {16'h0, dat_i[31:16]};
            SEL_H1:  dat_o = {16'h0, dat_i[15:0]};
            SEL_W:   dat_o = dat_i;
            default: dat_o = '0;
        endcase
    end

endmodule

// File: rtl/aemb_dwb_ctrl.sv
// AEMB data Wishbone cycle controller: captures a load/store, runs one classic
// cycle with timeout, stalls the pipeline via gena and flags bus errors.
module aemb_dwb_ctrl
    import aemb_pkg::*;
#(
    parameter int DW  = 32,
    parameter int TMO = 255
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic          xs_req,
    input  logic          xs_we,
    input  logic [DW-1:2] xs_adr,
    input  logic [3:0]    xs_sel,
    input  logic [31:0]   xs_dat,
    output logic          gena,
    output logic [31:0]   rDWBDI,
    output logic          dbe_o,
    aemb_dwb_ctrl_if.master dwb
);

    localparam logic [7:0] TMO_C = 8'(TMO);

    dwb_state_e    state_q, state_d;
    logic          we_q;
    logic [DW-1:2] adr_q;
    logic [3:0]    sel_q;
    logic [31:0]   dat_q;
    logic [31:0]   rd_q;
    logic [7:0]    tmo_q, tmo_d;
    logic [31:0]   lane_dat;

    aemb_dwb_lane u_lane (
        .sel_i (sel_q),
        .dat_i (dwb.dwb_dat_i),
        .dat_o (lane_dat)
    );

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        gena    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gena = !xs_req;
                if (xs_req) begin
                    state_d = ST_BUS;
                    tmo_d   = TMO_C;
                end
            end
            ST_BUS: begin
                // error outranks ack; an ack in the last allowed cycle outranks the timeout
                if (dwb.dwb_err_i) begin
                    state_d = ST_ERR;
                end else if (dwb.dwb_ack_i) begin
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q - 8'd1;
                    if (TMO_C != 8'd0 && tmo_q == 8'd1)
                        state_d = ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                gena    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            rd_q    <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            if (state_q == ST_IDLE && xs_req) begin
                we_q  <= xs_we;
                adr_q <= xs_adr;
                sel_q <= xs_sel;
                dat_q <= xs_dat;
            end
            if (state_q == ST_BUS && !dwb.dwb_err_i && dwb.dwb_ack_i && !we_q)
                rd_q <= lane_dat;
        end
    end

    assign dwb.dwb_cyc_o = (state_q == ST_BUS);
    assign dwb.dwb_stb_o = (state_q == ST_BUS);
    assign dwb.dwb_we_o  = we_q;
    assign dwb.dwb_adr_o = adr_q;
    assign dwb.dwb_sel_o = sel_q;
    assign dwb.dwb_dat_o = dat_q;
    assign rDWBDI        = rd_q;
    assign dbe_o         = (state_q == ST_ERR);

endmodule
